// File: rtl/commit_trace_fifo_pkg.sv
// trace_pkg: record tags, default widths and the trace record layout
package trace_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
    localparam int DEPTH_DEF  = 16;
    localparam int TS_W_DEF   = 16;
    localparam int CNT_W_DEF  = 8;
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_REG   = 2'd1,
        TAG_STORE = 2'd2
    } trace_tag_e;
    typedef struct packed {
        trace_tag_e              tag;
        logic [ADDR_W_DEF-1:0]   addr;
        logic [DATA_W_DEF-1:0]   data;
        logic [TS_W_DEF-1:0]     ts;
    } trace_rec_t;
endpackage

// File: rtl/commit_trace_fifo_if.sv
// commit_trace_fifo_if: valid/ready record stream toward the trace sink
interface commit_trace_fifo_if
    import trace_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TS_W   = TS_W_DEF
);
    logic              m_valid;
    logic              m_ready;
    logic [1:0]        m_tag;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [TS_W-1:0]   m_ts;
    modport master (output m_valid, m_tag, m_addr, m_data, m_ts, input m_ready);
    modport slave  (input m_valid, m_tag, m_addr, m_data, m_ts, output m_ready);
endinterface

// File: rtl/commit_trace_fifo_fifo.sv
// trace_fifo_2w1r: circular buffer accepting up to two pushes and one pop per cycle
module trace_fifo_2w1r
    import trace_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push0,
    input  logic [W-1:0]  din0,
    input  logic          push1,
    input  logic [W-1:0]  din1,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic [LW-1:0] free
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_pop;
    assign do_pop = pop & (level != '0);
    assign dout   = mem[rp];
    assign free   = LW'(DEPTH) - level;
    // push1 is only ever used together with push0, so it lands in the slot after it
    always_ff @(posedge clk) begin
        if (push0) mem[wp] <= din0;
        if (push1) mem[wp + AW'(1)] <= din1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + AW'(push0) + AW'(push1);
            rp    <= rp + AW'(do_pop);
            level <= level + LW'(push0) + LW'(push1) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: packs core write-back and store events into timestamped
// records, buffers them and counts events dropped for lack of space
module commit_trace_fifo
    import trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr,
    input  logic              reg_write_sig,
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    commit_trace_fifo_if.master m,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int W = 2 + ADDR_W + DATA_W + TS_W;
    logic [TS_W-1:0]  ts;
    logic             reg_ev, st_ev, push0, push1, pop;
    logic [1:0]       dropped;
    logic [LW-1:0]    free;
    logic [W-1:0]     rec_reg, rec_st, head;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W:0]   cnt_sum;
    assign reg_ev  = enable & reg_write_sig & (reg_num != 5'd0);
    assign st_ev   = enable & wr;
    assign rec_reg = {TAG_REG, ADDR_W'(reg_num), reg_data, ts};
    assign rec_st  = {TAG_STORE, addr, wr_data, ts};
    // free space is taken before this cycle's pop, so a pop never makes room
    assign push0   = (reg_ev | st_ev) & (free != '0);
    assign push1   = reg_ev & st_ev & (free >= LW'(2));
    assign dropped = ({1'b0, reg_ev} + {1'b0, st_ev}) - ({1'b0, push0} + {1'b0, push1});
    assign pop     = m.m_valid & m.m_ready;
    assign cnt_base = clr ? '0 : drop_cnt;
    assign cnt_sum  = {1'b0, cnt_base} + {{(CNT_W-1){1'b0}}, dropped};
    trace_fifo_2w1r #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .din0  (reg_ev ? rec_reg : rec_st),
        .push1 (push1),
        .din1  (rec_st),
        .pop   (pop),
        .dout  (head),
        .level (level),
        .free  (free)
    );
    assign m.m_valid = level != '0;
    assign {m.m_tag, m.m_addr, m.m_data, m.m_ts} = m.m_valid ? head : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts       <= ts + TS_W'(1);
            overflow <= (overflow & ~clr) | (dropped != 2'd0);
            drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule
